// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter that shares one register-file read port among NUM_REQ requesters.
// Grant and read select are combinational; each granted read returns as a registered, tagged response.
module regfile_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter bit XZR_EN     = 1'b1,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ADDR_WIDTH-1:0]         rd_sel,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data
);

  // Handshake: a requester holds req/req_addr until its gnt bit is seen; gnt
  // is the acceptance, and req still high on the next cycle is a new request.

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            have_gnt;
  logic            is_xzr;

  // Scan from ptr upward, modulo NUM_REQ; first set request wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Reset suppresses the grant so nothing requested during reset gets a response.
  assign have_gnt = found && !reset;

  always_comb begin
    gnt    = '0;
    rd_sel = '0;
    if (have_gnt) begin
      gnt[winner] = 1'b1;
      rd_sel      = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign is_xzr = XZR_EN && (rd_sel == ADDR_WIDTH'(31));

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= have_gnt;
      if (have_gnt) begin
        ptr      <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        rsp_id   <= winner;
        rsp_data <= is_xzr ? '0 : rd_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: two instances (XZR_EN=1 and XZR_EN=0) share stimulus,
// a reference model predicts grants and queues expected responses for a separate monitor.
module tb_regfile_read_arbiter;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int IW = 2;
  localparam int EW = 1 + IW + 2 * DW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      gnt1, gnt0;
  logic [AW-1:0]     rd_sel1, rd_sel0;
  logic [DW-1:0]     rd_data1, rd_data0;
  logic              rsp_valid1, rsp_valid0;
  logic [IW-1:0]     rsp_id1, rsp_id0;
  logic [DW-1:0]     rsp_data1, rsp_data0;

  logic [DW-1:0] rf [32];
  assign rd_data1 = rf[rd_sel1];
  assign rd_data0 = rf[rd_sel0];

  regfile_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .XZR_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt1),
    .rd_sel(rd_sel1), .rd_data(rd_data1), .rsp_valid(rsp_valid1), .rsp_id(rsp_id1),
    .rsp_data(rsp_data1)
  );

  regfile_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .XZR_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt0),
    .rd_sel(rd_sel0), .rd_data(rd_data0), .rsp_valid(rsp_valid0), .rsp_id(rsp_id0),
    .rsp_data(rsp_data0)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  int            m_ptr;
  logic [IW-1:0] m_id;
  logic [DW-1:0] m_d1, m_d0;
  int            wait_cnt [N];
  logic [AW-1:0] addr_v [N];
  logic [EW-1:0] exp_q [$];

  // pending register-file write, applied just after the active edge
  logic          wr_en;
  logic [4:0]    wr_idx;
  logic [DW-1:0] wr_val;

  // driver: one cycle of stimulus, grant check, expected response queued
  task automatic step(input logic rst, input logic [N-1:0] r, output int w);
    logic [N-1:0]  exp_gnt;
    logic [AW-1:0] exp_sel;
    @(posedge clk);
    #1;
    reset = rst;
    req   = r;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_v[i];
    if (wr_en) rf[wr_idx] = wr_val;
    @(negedge clk);
    w = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (w < 0 && r[i]) w = i;
      end
    end
    exp_gnt = '0;
    exp_sel = '0;
    if (w >= 0) begin
      exp_gnt[w] = 1'b1;
      exp_sel    = addr_v[w];
    end
    check("gnt_xzr1", 64'(gnt1), 64'(exp_gnt));
    check("gnt_xzr0", 64'(gnt0), 64'(exp_gnt));
    check("rd_sel_xzr1", 64'(rd_sel1), 64'(exp_sel));
    check("rd_sel_xzr0", 64'(rd_sel0), 64'(exp_sel));
    for (int i = 0; i < N; i++) begin
      if (!rst && r[i] && w != i) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (r[i]) check("fairness_wait", 64'(wait_cnt[i]), (wait_cnt[i] < N) ? 64'(wait_cnt[i]) : 64'(N - 1));
    end
    if (rst) begin
      m_ptr = 0;
      m_id  = '0;
      m_d1  = '0;
      m_d0  = '0;
      exp_q.push_back({1'b0, m_id, m_d1, m_d0});
    end else if (w >= 0) begin
      m_id  = IW'(w);
      m_d0  = rf[addr_v[w]];
      m_d1  = (addr_v[w] == 5'd31) ? '0 : rf[addr_v[w]];
      m_ptr = (w + 1) % N;
      exp_q.push_back({1'b1, m_id, m_d1, m_d0});
    end else begin
      exp_q.push_back({1'b0, m_id, m_d1, m_d0});
    end
  endtask

  // scoreboard monitor: each entry is the response expected one edge after it was queued
  always @(posedge clk) begin
    #3;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("rsp_valid_xzr1", 64'(rsp_valid1), 64'(e[EW-1]));
      check("rsp_valid_xzr0", 64'(rsp_valid0), 64'(e[EW-1]));
      check("rsp_id_xzr1", 64'(rsp_id1), 64'(e[2*DW +: IW]));
      check("rsp_id_xzr0", 64'(rsp_id0), 64'(e[2*DW +: IW]));
      check("rsp_data_xzr1", rsp_data1, e[DW +: DW]);
      check("rsp_data_xzr0", rsp_data0, e[0 +: DW]);
    end
  end

  initial begin
    int w;
    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_val   = '0;
    m_ptr    = 0;
    m_id     = '0;
    m_d1     = '0;
    m_d0     = '0;
    for (int i = 0; i < N; i++) begin
      wait_cnt[i] = 0;
      addr_v[i]   = AW'(i + 8);
    end
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    rf[5]  = 64'h1234;
    rf[31] = 64'hDEAD;

    // reset then idle
    repeat (2) step(1'b1, '0, w);
    repeat (5) step(1'b0, '0, w);

    // single requester
    addr_v[2] = 5'd5;
    step(1'b0, 4'b0100, w);
    check("single_winner", 64'(w), 64'd2);
    step(1'b0, '0, w);

    // all requesters held high after reset
    step(1'b1, '0, w);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'b1111, w);
      check("all_req_order", 64'(w), 64'(k % 4));
    end

    // pointer skip and wrap
    step(1'b1, '0, w);
    step(1'b0, 4'b1000, w);
    check("skip_first", 64'(w), 64'd3);
    step(1'b0, 4'b0110, w);
    check("skip_a", 64'(w), 64'd1);
    step(1'b0, 4'b0110, w);
    check("skip_b", 64'(w), 64'd2);
    step(1'b0, 4'b0110, w);
    check("skip_c", 64'(w), 64'd1);
    step(1'b0, '0, w);

    // zero register, compared on both instances by the monitor
    addr_v[0] = 5'd31;
    step(1'b0, 4'b0001, w);
    check("xzr_winner", 64'(w), 64'd0);
    step(1'b0, '0, w);

    // reset mid-stream
    step(1'b1, '0, w);
    repeat (3) step(1'b0, 4'b1111, w);
    step(1'b1, 4'b1111, w);
    step(1'b0, 4'b1111, w);
    check("post_reset_winner", 64'(w), 64'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) addr_v[i] = AW'($urandom_range(0, 31));
      wr_en  = ($urandom_range(0, 1) == 1);
      wr_idx = 5'($urandom_range(0, 31));
      wr_val = {$urandom, $urandom};
      step(($urandom_range(0, 49) == 0), N'($urandom_range(0, 15)), w);
    end
    wr_en = 1'b0;
    step(1'b0, '0, w);
    repeat (2) @(posedge clk);
    #5;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Round-robin arbiter that shares one register-file read port among several requesters. The read port is the 32:1 select-mux tree, with `rd_sel` feeding the mux select and `rd_data` as the mux output. Each cycle the arbiter grants at most one requester, drives that requester's register address onto the port and registers the returned data into a tagged response. It sits between the register file and the pipeline stages or debug logic that contend for a spare read port.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_WIDTH`, default 5: register index width; 32 registers.
- `DATA_WIDTH`, default 64: register width.
- `XZR_EN`, default 1: when 1, index 31 reads as zero regardless of `rd_data`.

Ports:
- `clk`  in  1: the only clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req`  in  NUM_REQ: request vector, one bit per requester.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH: register index per requester; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `gnt`  out  NUM_REQ: one-hot grant, combinational; all zero when there is no winner.
- `rd_sel`  out  ADDR_WIDTH: select to the read mux; combinational.
- `rd_data`  in  DATA_WIDTH: read-mux output, valid in the same cycle as `rd_sel`.
- `rsp_valid`  out  1: response valid, registered.
- `rsp_id`  out  $clog2(NUM_REQ): index of the granted requester, registered.
- `rsp_data`  out  DATA_WIDTH: read data, registered.

## Operation

- State:
  - priority pointer `ptr`, range 0..NUM_REQ-1;
  - response registers `rsp_valid`, `rsp_id`, `rsp_data`.
- Arbitration, combinational each cycle:
  - Winner = the first i with `req[i]`=1, scanning `ptr`, `ptr`+1, ... modulo NUM_REQ.
  - `gnt[winner]`=1; every other `gnt` bit = 0.
  - No bit of `req` set -> `gnt`=0.
- `rd_sel` = `req_addr` slice of the winner; 0 when there is no winner.
- Pointer update on a clock edge with a grant: `ptr` <= (winner+1) mod NUM_REQ. With no grant, `ptr` holds.
- Response update on a clock edge:
  - `rsp_valid` <= |gnt.
  - On a grant: `rsp_id` <= winner.
  - On a grant: `rsp_data` <= (XZR_EN && rd_sel==31) ? 0 : rd_data.
  - With no grant, `rsp_id` and `rsp_data` hold their previous values.
- Handshake:
  - A requester holds `req` and `req_addr` stable until it sees its `gnt` bit.
  - A grant is an acceptance: the requester deasserts `req` next cycle or issues a new address.
  - `req` held high after a grant is treated as a new request and competes normally.
- Fairness: a requester holding `req` continuously is granted within NUM_REQ cycles.
- Width rules: `rd_sel` is ADDR_WIDTH bits with no truncation. `rsp_id` is zero-extended to $clog2(NUM_REQ) bits.

## Timing

- Reset, on any clock edge with `reset`=1, whether or not a grant or response is in progress:
  - `ptr`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0.
  - `gnt` forced to 0 and `rd_sel` forced to 0 during the reset cycle.
  - No response is produced for a request presented during reset.
- Latency:
  - Grant in cycle N (combinational from `req` and `ptr`).
  - `rsp_valid`/`rsp_data` for that grant appear in cycle N+1.
  - One response per cycle; back-to-back grants give back-to-back responses.
- Throughput: one read per cycle sustained.
- Reset mid-operation:
  - A grant issued in the cycle that `reset` is sampled high is dropped.
  - `rsp_valid`=0 in the following cycle.
- Simultaneous events:
  - Requests from all requesters in the same cycle: exactly one is granted, by the rule above.
  - A requester granted in cycle N with `req` still high competes in N+1 against the rotated pointer.
- Wrap-around: winner = NUM_REQ-1 -> `ptr` <= 0.
- Single requester with `req` held continuously: granted every cycle.

## Test plan

- Reset then idle:
  - Stimulus: `reset`=1 for 2 cycles, then `req`=0 for 5 cycles.
  - Response: `gnt`=0, `rd_sel`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0 throughout; `ptr` stays 0.
- Single requester:
  - Stimulus: `req`=4'b0100, `req_addr[2]`=5, `rd_data`=64'h1234.
  - Response: `gnt`=4'b0100 and `rd_sel`=5 in the same cycle; next cycle `rsp_valid`=1, `rsp_id`=2, `rsp_data`=64'h1234.
- All requesters held high for 8 cycles after reset:
  - Response: grant order 0,1,2,3,0,1,2,3.
  - Response: `rsp_id` sequence 0,1,2,3,0,1,2,3 delayed by one cycle, with no idle gaps.
- Pointer skip and wrap:
  - Stimulus: after a grant to requester 3 (`ptr`=0), assert `req`=4'b0110.
  - Response: requester 1 granted, then requester 2, then requester 1.
- Zero register:
  - Stimulus: `req_addr[0]`=31, `rd_data`=64'hDEAD, XZR_EN=1.
  - Response: `rsp_data`=0.
  - Stimulus: same with XZR_EN=0.
  - Response: `rsp_data`=64'hDEAD.
- Reset mid-stream:
  - Stimulus: all requesters active; `reset`=1 for one cycle at cycle 3.
  - Response: `rsp_valid`=0 in cycle 4; the first grant after reset goes to requester 0.
